// File: rtl/mems_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mems_spi_arbiter
// Description : Shares one DAC SPI master between the MEMS scan sequencer and
//               an auxiliary configuration requester. One command is picked
//               at a time, launched with a single-cycle start pulse, and the
//               master's busy flag is tracked to completion. Scan traffic has
//               priority; aux is guaranteed a slot after STARVE_MAX scan grants
//               while it is waiting.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               scan_req/data/ack - scan command handshake (ack = 1-cycle pulse)
//               aux_req/data/ack  - aux command handshake (ack = 1-cycle pulse)
//               spi_start         - 1-cycle launch pulse to the SPI master
//               spi_data          - command word held for the whole transfer
//               spi_busy          - SPI master transfer in progress
//               owner             - source of current/last grant (0 scan, 1 aux)
//               spi_err           - sticky: busy never rose after a launch
// Revision    : 1.0 - initial release
// ============================================================================
module mems_spi_arbiter #(
  parameter int DATA_W     = 24,
  parameter int STARVE_MAX = 8,
  parameter int BUSY_TO    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [DATA_W-1:0] scan_data,
  output logic              scan_ack,
  input  logic              aux_req,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_ack,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_busy,
  output logic              owner,
  output logic              spi_err
);

  localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);
  localparam logic [3:0] c_busy_to    = 4'(BUSY_TO);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_starve_cnt;
  logic [7:0]        w_starve_nxt;
  logic [3:0]        r_to_cnt;
  logic [3:0]        w_to_nxt;
  logic              r_spi_start;
  logic              w_start_nxt;
  logic              r_scan_ack;
  logic              w_scan_ack_nxt;
  logic              r_aux_ack;
  logic              w_aux_ack_nxt;
  logic [DATA_W-1:0] r_spi_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_owner;
  logic              w_owner_nxt;
  logic              r_spi_err;
  logic              w_err_nxt;
  logic              w_aux_wins;

  // Aux takes the slot when scan is idle, or when it has already watched
  // STARVE_MAX scan grants go by while waiting.
  assign w_aux_wins = !scan_req || (aux_req && (r_starve_cnt == c_starve_max));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= 8'd0;
      r_to_cnt     <= 4'd0;
      r_spi_start  <= 1'b0;
      r_scan_ack   <= 1'b0;
      r_aux_ack    <= 1'b0;
      r_spi_data   <= '0;
      r_owner      <= 1'b0;
      r_spi_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_to_cnt     <= w_to_nxt;
      r_spi_start  <= w_start_nxt;
      r_scan_ack   <= w_scan_ack_nxt;
      r_aux_ack    <= w_aux_ack_nxt;
      r_spi_data   <= w_data_nxt;
      r_owner      <= w_owner_nxt;
      r_spi_err    <= w_err_nxt;
    end
  end

  // Start and ack are computed on the way into LAUNCH so that, once
  // registered, they are high exactly for the LAUNCH cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve_cnt;
    w_to_nxt       = r_to_cnt;
    w_start_nxt    = 1'b0;
    w_scan_ack_nxt = 1'b0;
    w_aux_ack_nxt  = 1'b0;
    w_data_nxt     = r_spi_data;
    w_owner_nxt    = r_owner;
    w_err_nxt      = r_spi_err;

    case (r_state)
      IDLE: begin
        if (!aux_req) begin
          w_starve_nxt = 8'd0;
        end
        if (!spi_busy && (scan_req || aux_req)) begin
          w_state_nxt = LAUNCH;
          w_start_nxt = 1'b1;
          if (w_aux_wins) begin
            w_data_nxt    = aux_data;
            w_owner_nxt   = 1'b1;
            w_aux_ack_nxt = 1'b1;
            w_starve_nxt  = 8'd0;
          end else begin
            w_data_nxt     = scan_data;
            w_owner_nxt    = 1'b0;
            w_scan_ack_nxt = 1'b1;
            if (aux_req && (r_starve_cnt != c_starve_max)) begin
              w_starve_nxt = r_starve_cnt + 8'd1;
            end
          end
        end
      end

      LAUNCH: begin
        w_state_nxt = WAIT_BUSY;
        w_to_nxt    = 4'd0;
      end

      WAIT_BUSY: begin
        if (spi_busy) begin
          w_state_nxt = WAIT_DONE;
        end else begin
          w_to_nxt = r_to_cnt + 4'd1;
          // The command is dropped on timeout; the error flag tells the host.
          if ((r_to_cnt + 4'd1) == c_busy_to) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!spi_busy) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign spi_start = r_spi_start;
  assign scan_ack  = r_scan_ack;
  assign aux_ack   = r_aux_ack;
  assign spi_data  = r_spi_data;
  assign owner     = r_owner;
  assign spi_err   = r_spi_err;

endmodule
`default_nettype wire

// File: tb/tb_mems_spi_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mems_spi_arbiter
// Description : Self-checking bench for mems_spi_arbiter: vector table,
//               directed multi-cycle sequences and a randomized run against a
//               transaction-level arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mems_spi_arbiter;

  localparam int DATA_W     = 24;
  localparam int STARVE_MAX = 4;
  localparam int BUSY_TO    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              scan_req = 1'b0;
  logic [DATA_W-1:0] scan_data = '0;
  logic              aux_req = 1'b0;
  logic [DATA_W-1:0] aux_data = '0;
  logic              spi_busy = 1'b0;
  logic              scan_ack, aux_ack, spi_start, owner, spi_err;
  logic [DATA_W-1:0] spi_data;

  always #5 clk = ~clk;

  mems_spi_arbiter #(
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX),
    .BUSY_TO   (BUSY_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_req (scan_req),
    .scan_data(scan_data),
    .scan_ack (scan_ack),
    .aux_req  (aux_req),
    .aux_data (aux_data),
    .aux_ack  (aux_ack),
    .spi_start(spi_start),
    .spi_data (spi_data),
    .spi_busy (spi_busy),
    .owner    (owner),
    .spi_err  (spi_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit master_en = 1'b0, master_rand = 1'b0, req_en = 1'b0, model_en = 1'b0;
  int m_delay = 2, m_len = 10, m_delay_cnt = 0, m_len_cnt = 0;
  int p_scan = 0, p_aux = 0;
  int starve_m = 0;
  bit grants[$];

  typedef struct {
    logic              sreq, areq, busy;
    logic [DATA_W-1:0] sdata, adata;
    logic              e_start, e_sack, e_aack, e_owner;
    logic [DATA_W-1:0] e_data;
  } vec_t;
  vec_t vecs[6];

  function automatic void chk_bit(string name, logic act, logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endfunction

  function automatic void chk_word(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Transaction-level arbitration model: called at each sample point while the
  // request inputs still hold the values the DUT saw at the preceding edge.
  function automatic void model_step();
    bit exp_aux;
    if (spi_start) begin
      exp_aux = !scan_req || (aux_req && (starve_m == STARVE_MAX));
      chk_bit("grant_while_busy", spi_busy, 1'b0);
      chk_bit("grant_owner", owner, exp_aux);
      chk_word("grant_data", spi_data, exp_aux ? aux_data : scan_data);
      chk_bit("grant_scan_ack", scan_ack, !exp_aux);
      chk_bit("grant_aux_ack", aux_ack, exp_aux);
      grants.push_back(exp_aux);
      if (exp_aux || !aux_req) starve_m = 0;
      else if (starve_m < STARVE_MAX) starve_m++;
    end else begin
      chk_bit("ack_without_start", scan_ack | aux_ack, 1'b0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (model_en) model_step();
    if (master_en) begin
      if (m_delay_cnt > 0) begin
        m_delay_cnt--;
        if (m_delay_cnt == 0) begin
          spi_busy  = 1'b1;
          m_len_cnt = m_len;
        end
      end else if (m_len_cnt > 0) begin
        m_len_cnt--;
        if (m_len_cnt == 0) spi_busy = 1'b0;
      end
      if (spi_start) begin
        if (master_rand) begin
          m_delay = int'($urandom_range(2, 1));
          m_len   = int'($urandom_range(6, 1));
        end
        m_delay_cnt = m_delay;
      end
    end
    if (req_en) begin
      if (scan_req && scan_ack) scan_req = 1'b0;
      if (!scan_req && int'($urandom_range(99, 0)) < p_scan) begin
        scan_req  = 1'b1;
        scan_data = DATA_W'($urandom);
      end
      if (aux_req && aux_ack) aux_req = 1'b0;
      if (!aux_req && int'($urandom_range(99, 0)) < p_aux) begin
        aux_req  = 1'b1;
        aux_data = DATA_W'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    req_en = 1'b0; model_en = 1'b0; master_en = 1'b0;
    m_delay_cnt = 0; m_len_cnt = 0;
    scan_req = 1'b0; aux_req = 1'b0; spi_busy = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_master(input bit rnd, input int dly, input int len);
    master_rand = rnd; m_delay = dly; m_len = len;
    m_delay_cnt = 0; m_len_cnt = 0;
    master_en = 1'b1;
  endtask

  task automatic wait_start(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (spi_start) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen, saw;
    int t_prev;
    logic [DATA_W-1:0] sd[5];

    //              sreq  areq  busy  sdata         adata         start sack  aack  own   data
    vecs[0] = '{1'b1, 1'b0, 1'b0, 24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b1, 1'b0, 1'b0, 24'hA5A5A5};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b0, 1'b1, 1'b1, 24'h5A5A5A};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 24'h123456, 24'h654321, 1'b1, 1'b1, 1'b0, 1'b0, 24'h123456};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};

    // Reset state
    do_reset();
    chk_bit("rst_spi_start", spi_start, 1'b0);
    chk_bit("rst_scan_ack", scan_ack, 1'b0);
    chk_bit("rst_aux_ack", aux_ack, 1'b0);
    chk_word("rst_spi_data", spi_data, '0);
    chk_bit("rst_owner", owner, 1'b0);
    chk_bit("rst_spi_err", spi_err, 1'b0);

    // Single-arbitration vectors from a freshly reset arbiter
    for (int v = 0; v < 6; v++) begin
      do_reset();
      scan_req = vecs[v].sreq; aux_req = vecs[v].areq; spi_busy = vecs[v].busy;
      scan_data = vecs[v].sdata; aux_data = vecs[v].adata;
      tick();
      chk_bit($sformatf("vec%0d_start", v), spi_start, vecs[v].e_start);
      chk_bit($sformatf("vec%0d_scan_ack", v), scan_ack, vecs[v].e_sack);
      chk_bit($sformatf("vec%0d_aux_ack", v), aux_ack, vecs[v].e_aack);
      chk_bit($sformatf("vec%0d_owner", v), owner, vecs[v].e_owner);
      chk_word($sformatf("vec%0d_data", v), spi_data, vecs[v].e_data);
    end

    // Scan only, five back-to-back commands, master busy 10 cycles
    do_reset();
    start_master(1'b0, 2, 10);
    sd[0] = 24'h100001; sd[1] = 24'h200002; sd[2] = 24'h300003;
    sd[3] = 24'h400004; sd[4] = 24'h500005;
    scan_req = 1'b1; scan_data = sd[0];
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start(40, seen);
      chk_bit($sformatf("scan5_start%0d", k), seen, 1'b1);
      chk_word($sformatf("scan5_data%0d", k), spi_data, sd[k]);
      chk_bit($sformatf("scan5_ack%0d", k), scan_ack, 1'b1);
      if (k > 0) chk_int($sformatf("scan5_spacing%0d", k), cyc - t_prev, 14);
      t_prev = cyc;
      if (k < 4) scan_data = sd[k+1];
      else scan_req = 1'b0;
    end
    for (int i = 0; i < 16; i++) tick();

    // Aux only
    aux_req = 1'b1; aux_data = 24'h380001;
    wait_start(10, seen);
    chk_bit("aux_start", seen, 1'b1);
    chk_word("aux_data", spi_data, 24'h380001);
    chk_bit("aux_ack", aux_ack, 1'b1);
    chk_bit("aux_owner", owner, 1'b1);
    saw = scan_ack;
    aux_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      saw |= scan_ack;
    end
    chk_bit("aux_no_scan_ack", saw, 1'b0);

    // Busy timeout: master never answers
    master_en = 1'b0; spi_busy = 1'b0;
    scan_req = 1'b1; scan_data = 24'h0F0F0F;
    wait_start(10, seen);
    chk_bit("to_start", seen, 1'b1);
    scan_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_bit("to_err_not_yet", spi_err, 1'b0);
    tick();
    chk_bit("to_err_set", spi_err, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk_bit("to_err_sticky", spi_err, 1'b1);
    start_master(1'b0, 2, 3);
    aux_req = 1'b1; aux_data = 24'h123456;
    wait_start(10, seen);
    chk_bit("to_next_served", seen, 1'b1);
    chk_word("to_next_data", spi_data, 24'h123456);
    aux_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_bit("to_err_still", spi_err, 1'b1);

    // Reset during WAIT_DONE, then busy held high with both requests pending
    start_master(1'b0, 2, 10);
    scan_req = 1'b1; scan_data = 24'h0ABCDE;
    wait_start(10, seen);
    chk_bit("rmid_start", seen, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    master_en = 1'b0; spi_busy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bit("rmid_spi_start", spi_start, 1'b0);
    chk_bit("rmid_scan_ack", scan_ack, 1'b0);
    chk_bit("rmid_aux_ack", aux_ack, 1'b0);
    chk_word("rmid_spi_data", spi_data, '0);
    chk_bit("rmid_owner", owner, 1'b0);
    chk_bit("rmid_spi_err", spi_err, 1'b0);
    aux_req = 1'b1; aux_data = 24'h777777;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw |= spi_start | scan_ack | aux_ack;
    end
    chk_bit("busy_hold_no_grant", saw, 1'b0);
    spi_busy = 1'b0;
    wait_start(2, seen);
    chk_bit("busy_release_start", seen, 1'b1);
    chk_bit("busy_release_owner", owner, 1'b0);
    chk_word("busy_release_data", spi_data, 24'h0ABCDE);
    chk_bit("busy_release_scan_ack", scan_ack, 1'b1);

    // Randomized traffic against the arbitration model
    do_reset();
    starve_m = 0; grants.delete();
    start_master(1'b1, 1, 1);
    p_scan = 70; p_aux = 30;
    req_en = 1'b1; model_en = 1'b1;
    for (int i = 0; i < 800; i++) tick();
    chk_bit("rand_no_err", spi_err, 1'b0);
    chk_bit("rand_some_grants", grants.size() > 20, 1'b1);

    // Continuous scan with aux held: scan x4, aux, scan x4, aux
    do_reset();
    starve_m = 0; grants.delete();
    start_master(1'b0, 1, 2);
    p_scan = 100; p_aux = 100;
    req_en = 1'b1; model_en = 1'b1;
    for (int i = 0; i < 400 && grants.size() < 10; i++) tick();
    chk_int("starve_grant_count", grants.size(), 10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk_bit($sformatf("starve_order%0d", i), grants[i], (i % 5) == 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
